// File: rtl/arbiter_pkg.sv
// arbiter_pkg: width and index helpers shared by arbiter_rr, its interface and lane FIFOs
package arbiter_pkg;

    // Bits needed to index 0..n-1, never less than one.
    function automatic int log2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b >= n) ? a + b - n : a + b;
    endfunction

    // Port 0 occupies the most significant slice of the packed data bus.
    function automatic int slice_lo(input int i, input int ports, input int width);
        return (ports - 1 - i) * width;
    endfunction

endpackage

// File: rtl/arbiter_rr_if.sv
// arbiter_rr_if: producer lanes plus the merged consumer stream of arbiter_rr
// ARBITER_RR_SRC_TAG_EN adds src, the source port of the word held in q
interface arbiter_rr_if import arbiter_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int PORTS = 8
);
    logic [0:PORTS-1] push;
    logic [WIDTH*PORTS-1:0] d;
    logic [0:PORTS-1] full;
    logic [0:PORTS-1] almost_full;
    logic [WIDTH-1:0] q;
    logic valid;
    logic stall;
`ifdef ARBITER_RR_SRC_TAG_EN
    logic [log2(PORTS)-1:0] src;
    modport slave (input push, d, stall, output full, almost_full, q, valid, src);
    modport master (output push, d, stall, input full, almost_full, q, valid, src);
`else
    modport slave (input push, d, stall, output full, almost_full, q, valid);
    modport master (output push, d, stall, input full, almost_full, q, valid);
`endif
endinterface

// File: rtl/arbiter_lane_fifo.sv
// arbiter_lane_fifo: first-word-fall-through lane buffer with registered count, full and almost_full
module arbiter_lane_fifo import arbiter_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int ALMOST_FULL_THRESHOLD = 1,
    parameter int FIFO_DEPTH_ADDR_WIDTH = log2(FIFO_DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [FIFO_DEPTH_ADDR_WIDTH:0] count,
    output logic full,
    output logic almost_full
);
    localparam int AW = FIFO_DEPTH_ADDR_WIDTH;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] AF_LVL = (AW + 1)'(FIFO_DEPTH - ALMOST_FULL_THRESHOLD);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic wr, rd;

    // A push into a full lane is dropped even when the lane is popped that cycle.
    assign wr = push && !full;
    assign rd = pop && count != '0;
    assign dout = mem[rd_ptr];
    assign full = count == FULL_LVL;
    assign almost_full = count >= AF_LVL;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
        end

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= din;

endmodule

// File: rtl/arbiter_rr.sv
// arbiter_rr: per-port FWFT FIFOs merged onto one registered valid/stall stream by burst round-robin
// ARBITER_RR_SRC_TAG_EN adds the src output tagging each word with its source port
module arbiter_rr import arbiter_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int PORTS = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int ALMOST_FULL_THRESHOLD = 1,
    parameter int BURST_LEN = 1,
    parameter int PORTS_ADDR_WIDTH = log2(PORTS),
    parameter int FIFO_DEPTH_ADDR_WIDTH = log2(FIFO_DEPTH)
) (
    input logic clk,
    input logic rst,
    arbiter_rr_if.slave bus
);
    localparam int PAW = PORTS_ADDR_WIDTH;
    localparam int CW = FIFO_DEPTH_ADDR_WIDTH + 1;
    localparam int BW = log2(BURST_LEN);

    logic [WIDTH-1:0] head [PORTS];
    logic [CW-1:0] count [PORTS];
    logic [PORTS-1:0] pop;
    logic [PAW-1:0] ptr, ptr_n, g;
    logic [BW-1:0] bc, bc_n, bc_cur;
    logic [WIDTH-1:0] q_r;
    logic valid_r, found, load, more;

    for (genvar i = 0; i < PORTS; i++) begin : g_lane
        arbiter_lane_fifo #(
            .WIDTH(WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH),
            .ALMOST_FULL_THRESHOLD(ALMOST_FULL_THRESHOLD),
            .FIFO_DEPTH_ADDR_WIDTH(FIFO_DEPTH_ADDR_WIDTH)
        ) u_fifo (
            .clk(clk),
            .rst(rst),
            .push(bus.push[i]),
            .pop(pop[i]),
            .din(bus.d[slice_lo(i, PORTS, WIDTH) +: WIDTH]),
            .dout(head[i]),
            .count(count[i]),
            .full(bus.full[i]),
            .almost_full(bus.almost_full[i])
        );
    end

    assign load = !valid_r || !bus.stall;
    assign bus.q = q_r;
    assign bus.valid = valid_r;

    // A burst only continues on the port ptr already points at; any other winner starts fresh.
    always_comb begin
        found = 1'b0;
        g = ptr;
        for (int k = 0; k < PORTS; k++)
            if (!found && count[wrap_add(int'(ptr), k, PORTS)] != '0) begin
                found = 1'b1;
                g = PAW'(wrap_add(int'(ptr), k, PORTS));
            end
        bc_cur = (g == ptr) ? bc : '0;
        more = count[g] > CW'(1) || (bus.push[g] && !bus.full[g]);
        pop = '0;
        ptr_n = ptr;
        bc_n = bc;
        if (load && found) begin
            pop[g] = 1'b1;
            ptr_n = (int'(bc_cur) + 1 < BURST_LEN && more) ? g : (g == PAW'(PORTS - 1)) ? '0 : g + 1'b1;
            bc_n = (int'(bc_cur) + 1 < BURST_LEN && more) ? bc_cur + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ptr <= '0;
            bc <= '0;
            valid_r <= 1'b0;
            q_r <= '0;
        end else if (load) begin
            ptr <= ptr_n;
            bc <= bc_n;
            valid_r <= found;
            if (found) q_r <= head[g];
        end

`ifdef ARBITER_RR_SRC_TAG_EN
    logic [PAW-1:0] src_r;
    always_ff @(posedge clk or posedge rst)
        if (rst) src_r <= '0;
        else if (load && found) src_r <= g;
    assign bus.src = src_r;
`endif

endmodule

// File: tb/tb_arbiter_rr.sv
// tb_arbiter_rr: queue-model scoreboard for arbiter_rr with directed ordering tests and random traffic
// Data words carry their port number in bits [7:6] so arrival order can be checked by port.
module tb_arbiter_rr;
    localparam int W = 8;
    localparam int P = 4;
    localparam int DEP = 4;
    localparam int THR = 1;
    localparam int BL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arbiter_rr_if #(.WIDTH(W), .PORTS(P)) bus ();

    arbiter_rr #(
        .WIDTH(W),
        .PORTS(P),
        .FIFO_DEPTH(DEP),
        .ALMOST_FULL_THRESHOLD(THR),
        .BURST_LEN(BL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    logic [W-1:0] mq [P][$];
    int expq[$];
    int seen[$];
    int mptr = 0;
    int mbc = 0;
    bit mvalid = 0;
    int seqn [P];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-port word queues, a circular search from the favoured port, burst budget.
    task automatic model_step();
        int sel, c;
        bit ld, more;
        bit acc [P];
        if (rst) begin
            for (int i = 0; i < P; i++) mq[i].delete();
            expq.delete();
            mptr = 0;
            mbc = 0;
            mvalid = 0;
            return;
        end
        ld = !mvalid || !bus.stall;
        sel = -1;
        for (int k = 0; k < P; k++)
            if (sel < 0 && mq[(mptr + k) % P].size() > 0) sel = (mptr + k) % P;
        for (int i = 0; i < P; i++) acc[i] = bus.push[i] && mq[i].size() < DEP;
        if (ld) begin
            if (sel >= 0) begin
                expq.push_back(sel * 256 + int'(mq[sel].pop_front()));
                mvalid = 1;
                c = (sel == mptr) ? mbc : 0;
                more = mq[sel].size() > 0 || acc[sel];
                if (c + 1 < BL && more) begin
                    mptr = sel;
                    mbc = c + 1;
                end else begin
                    mptr = (sel + 1) % P;
                    mbc = 0;
                end
            end else mvalid = 0;
        end
        for (int i = 0; i < P; i++)
            if (acc[i]) mq[i].push_back(bus.d[(P-1-i)*W +: W]);
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    // Monitor: flags every cycle, q against the scoreboard head, pop on each transfer.
    initial forever begin
        @(negedge clk);
        #1;
        if (!rst) begin
            chk("valid", bus.valid, mvalid);
            for (int i = 0; i < P; i++) begin
                chk($sformatf("full[%0d]", i), bus.full[i], mq[i].size() == DEP);
                chk($sformatf("almost_full[%0d]", i), bus.almost_full[i], mq[i].size() >= DEP - THR);
            end
            if (bus.valid) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stale: q=%0h presented with no word expected", bus.q);
                end else begin
                    chk("q", bus.q, expq[0] & 255);
`ifdef ARBITER_RR_SRC_TAG_EN
                    chk("src", bus.src, expq[0] / 256);
`endif
                    if (!bus.stall) begin
                        seen.push_back(int'(bus.q[7:6]));
                        void'(expq.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input logic [0:P-1] m, input bit st);
        @(negedge clk);
        bus.stall = st;
        bus.push = m;
        for (int i = 0; i < P; i++) begin
            bus.d[(P-1-i)*W +: W] = {2'(i), 6'(seqn[i])};
            if (m[i]) seqn[i]++;
        end
    endtask

    function automatic bit busy();
        bit b;
        b = mvalid || expq.size() > 0;
        for (int i = 0; i < P; i++) b = b || mq[i].size() > 0;
        return b;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (busy() && n < 200) begin
            step('0, 1'b0);
            n++;
        end
        total++;
        if (busy()) begin
            bad++;
            $display("FAIL %s drain: words still pending after %0d cycles", name, n);
        end
    endtask

    task automatic check_seen(input string name, input int e[$]);
        chk({name, " count"}, seen.size(), e.size());
        foreach (e[k])
            if (k < seen.size()) chk($sformatf("%s order[%0d]", name, k), seen[k], e[k]);
    endtask

    initial begin
        int e[$];
        bus.push = '0;
        bus.d = '0;
        bus.stall = 1'b0;
        for (int i = 0; i < P; i++) seqn[i] = 0;
        #2;
        chk("reset valid", bus.valid, 0);
        chk("reset q", bus.q, 0);
        chk("reset full", bus.full, 0);
        chk("reset almost_full", bus.almost_full, 0);
        @(negedge clk);
        rst = 1'b0;

        // Burst of two per grant, with a five-cycle stall in the middle of the drain.
        seen.delete();
        repeat (3) step(4'b1111, 1'b1);
        repeat (3) step('0, 1'b0);
        repeat (5) step('0, 1'b1);
        drain("burst");
        e = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
        check_seen("burst", e);

        // Empty ports are skipped.
        seen.delete();
        repeat (2) step(4'b0101, 1'b0);
        drain("skip");
        e = '{1, 1, 3, 3};
        check_seen("skip", e);

        // Fill port 2 behind a stalled output word; the fifth push is dropped.
        seen.delete();
        step(4'b1000, 1'b1);
        step('0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step(4'b0010, 1'b1);
            @(posedge clk);
            #1;
            chk($sformatf("almost_full[2] after push %0d", k), bus.almost_full[2], k >= 3);
            chk($sformatf("full[2] after push %0d", k), bus.full[2], k >= 4);
        end
        drain("full");
        e = '{0, 2, 2, 2, 2};
        check_seen("full", e);

        // Asynchronous reset in the middle of a drain.
        repeat (3) step(4'b1111, 1'b0);
        repeat (2) step('0, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("mid reset valid", bus.valid, 0);
        chk("mid reset q", bus.q, 0);
        chk("mid reset full", bus.full, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) step('0, 1'b0);
        drain("after reset");

        repeat (1500) step(4'($urandom) & 4'($urandom), $urandom_range(0, 3) == 0);
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
